// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity codes and the parity helper
// used by both the transmitter and the receiver's parity checker.
package uart_pkg;

  localparam int unsigned MAX_DATA_BITS = 9;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Zero-extending the word leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic [1:0] mode);
    parity_bit = (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

  // Code 2'b11 behaves like PARITY_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    parity_enabled = (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// Counts baud_tick pulses within one serial bit and flags the last tick.
module uart_tick_counter #(
  parameter int unsigned SB_TICKS = 16
) (
  input  logic clk,
  input  logic i_rst,
  input  logic clear,
  input  logic baud_tick,
  output logic bit_end_c
);

  localparam int unsigned TICK_W = (SB_TICKS > 1) ? $clog2(SB_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SB_TICKS - 1);

  logic [TICK_W-1:0] tick_cnt;

  // clear wins over a coincident tick so the accept-cycle tick is dropped.
  assign bit_end_c = baud_tick && !clear && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      tick_cnt <= '0;
    end else if (clear) begin
      tick_cnt <= '0;
    end else if (baud_tick) begin
      tick_cnt <= bit_end_c ? '0 : tick_cnt + TICK_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity and stop bit,
// with every output driven straight from a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA_BITS   = 8,
  parameter logic [1:0]  FLAG_PARITY    = 2'b00,
  parameter logic        FLAG_STOP_BITS = 1'b1,
  parameter int unsigned SB_TICKS       = 16
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    baud_tick,
  input  logic                    tx_start,
  input  logic [NB_DATA_BITS-1:0] tx_data_in,
  output logic                    tx,
  output logic                    tx_busy,
  output logic                    tx_done
);

  localparam int unsigned CNT_W = (NB_DATA_BITS > 1) ? $clog2(NB_DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(NB_DATA_BITS - 1);
  localparam logic PARITY_EN = parity_enabled(FLAG_PARITY);

  uart_state_e             state, state_next;
  logic [NB_DATA_BITS-1:0] shift_q, shift_next;
  logic [NB_DATA_BITS-1:0] data_q, data_next;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_next;
  logic                    tx_next, busy_next, done_next;
  logic                    bit_end_c;

  uart_tick_counter #(
    .SB_TICKS (SB_TICKS)
  ) u_tick_counter (
    .clk       (clk),
    .i_rst     (i_rst),
    .clear     (state == ST_IDLE),
    .baud_tick (baud_tick),
    .bit_end_c (bit_end_c)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      data_q  <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_next;
      shift_q <= shift_next;
      data_q  <= data_next;
      bit_cnt <= bit_cnt_next;
      tx      <= tx_next;
      tx_busy <= busy_next;
      tx_done <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    data_next    = data_q;
    bit_cnt_next = bit_cnt;
    tx_next      = 1'b1;
    busy_next    = 1'b0;
    done_next    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // A request in the done cycle is dropped so each frame gets its pulse.
        if (tx_start && !tx_done) begin
          data_next    = tx_data_in;
          shift_next   = tx_data_in;
          bit_cnt_next = '0;
          state_next   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end_c) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end_c) begin
          shift_next   = shift_q >> 1;
          bit_cnt_next = bit_cnt + CNT_W'(1);
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_next = '0;
            if (PARITY_EN)           state_next = ST_PARITY;
            else if (FLAG_STOP_BITS) state_next = ST_STOP;
            else                     state_next = ST_IDLE;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_c) state_next = FLAG_STOP_BITS ? ST_STOP : ST_IDLE;
      end
      ST_STOP: begin
        if (bit_end_c) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Line level is chosen from the upcoming state so tx changes with it.
    unique case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = parity_bit(MAX_DATA_BITS'(data_q), FLAG_PARITY);
      default:   tx_next = 1'b1;
    endcase

    busy_next = (state_next != ST_IDLE);
    done_next = (state != ST_IDLE) && (state_next == ST_IDLE);
  end

endmodule
